// File: rtl/ray_dispatcher_pkg.sv
// Shared ray-tracer types: field widths, colour constants and the dispatcher FSM states.
package rt_pkg;
  localparam int ORIGIN_W = 28;
  localparam int DIR_W    = 31;
  localparam int COLOR_W  = 12;

  localparam logic [COLOR_W-1:0] BLACK = 12'h000;
  localparam logic [COLOR_W-1:0] WHITE = 12'hfff;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_e;
endpackage

// File: rtl/ray_dispatcher_if.sv
// Host/tracer/frame-buffer signal bundle for ray_dispatcher; slave is the dispatcher side.
interface ray_dispatcher_if import rt_pkg::*; #(
  parameter int ADDR_W = 19
);
  logic                start;
  logic                pause;
  logic [ORIGIN_W-1:0] cam_pos;
  logic [ORIGIN_W-1:0] init;
  logic [DIR_W-1:0]    dir;
  logic                ray_valid;
  logic [COLOR_W-1:0]  res_color;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOR_W-1:0]  fb_data;
  logic                busy;
  logic                done;

  modport master (
    output start, pause, cam_pos, res_color,
    input  init, dir, ray_valid, fb_we, fb_addr, fb_data, busy, done
  );

  modport slave (
    input  start, pause, cam_pos, res_color,
    output init, dir, ray_valid, fb_we, fb_addr, fb_data, busy, done
  );
endinterface

// File: rtl/ray_dispatcher_tag_delay.sv
// Fixed-depth shift register carrying {valid, payload}; reset clears only the valid bits.
module tag_delay #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 53
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_q[0] <= data_i;
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];
endmodule

// File: rtl/ray_dispatcher.sv
// Raster-scan primary ray issue into the tracer and address-aligned write-back of its colours.
module ray_dispatcher import rt_pkg::*; #(
  parameter int          H_RES   = 640,
  parameter int          V_RES   = 480,
  parameter int          LATENCY = 53,
  parameter logic [10:0] FOCAL   = 11'd512,
  parameter int          ADDR_W  = 19
) (
  input logic             clk,
  input logic             rst,
  ray_dispatcher_if.slave bus
);
  localparam int X_W = $clog2(H_RES) + 1;
  localparam int Y_W = $clog2(V_RES) + 1;
  localparam int D_W = $clog2(LATENCY + 1) + 1;

  rd_state_e           state_q;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [D_W-1:0]      drain_q;
  logic [ORIGIN_W-1:0] cam_q;
  logic                busy_q, done_q;
  logic                x_last, y_last, issue;
  logic signed [9:0]   dx_s, dy_s;

  logic                tag_vld;
  logic [ADDR_W-1:0]   tag_addr;
  logic                fb_we_q;
  logic [ADDR_W-1:0]   fb_addr_q;
  logic [COLOR_W-1:0]  fb_data_q;

  always_comb begin
    x_last = (x_q == X_W'(H_RES - 1));
    y_last = (y_q == Y_W'(V_RES - 1));
    x_d    = x_last ? '0 : x_q + 1'b1;
    y_d    = x_last ? y_q + 1'b1 : y_q;
    addr_d = addr_q + 1'b1;
    issue  = (state_q == ISSUE) && !bus.pause;
    dx_s   = 10'(x_q) - 10'(H_RES / 2);
    dy_s   = 10'(V_RES / 2) - 10'(y_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      cam_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= ISSUE;
          cam_q   <= bus.cam_pos;
          x_q     <= '0;
          y_q     <= '0;
          addr_q  <= '0;
          busy_q  <= 1'b1;
        end
        ISSUE: if (!bus.pause) begin
          x_q    <= x_d;
          y_q    <= y_d;
          addr_q <= addr_d;
          if (x_last && y_last) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        // Hold off DONE until the last ray's colour has left the tag line.
        DRAIN: if (drain_q == D_W'(LATENCY)) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          drain_q <= drain_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tag_delay #(.WIDTH(ADDR_W), .DEPTH(LATENCY)) u_tag (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (issue),
    .data_i (addr_q),
    .vld_o  (tag_vld),
    .data_o (tag_addr)
  );

  // Tag output and tracer colour arrive in the same cycle; register them together.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= BLACK;
    end else begin
      fb_we_q   <= tag_vld;
      fb_addr_q <= tag_addr;
      fb_data_q <= bus.res_color;
    end
  end

  assign bus.init      = cam_q;
  assign bus.dir       = (state_q == ISSUE) ? {dx_s, dy_s, FOCAL} : '0;
  assign bus.ray_valid = issue;
  assign bus.fb_we     = fb_we_q;
  assign bus.fb_addr   = fb_addr_q;
  assign bus.fb_data   = fb_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 viewport with a 3-cycle tracer model.
module tb_ray_dispatcher;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   rc[8];
  logic [11:0] tr0 = '0, tr1 = '0, tr2 = '0;

  ray_dispatcher_if #(.ADDR_W(3)) bus ();

  ray_dispatcher #(
    .H_RES(4), .V_RES(2), .LATENCY(3), .FOCAL(11'd512), .ADDR_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Tracer stand-in: colour = dx[3:0]*16 + dy[3:0], three clocks after the ray.
  always @(posedge clk) begin
    tr0 <= {4'h0, bus.dir[24:21], bus.dir[14:11]};
    tr1 <= tr0;
    tr2 <= tr1;
  end
  assign bus.res_color = tr2;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_dx(input int a);
    return 10'((a % 4) - 2);
  endfunction

  function automatic logic [9:0] exp_dy(input int a);
    return 10'(1 - (a / 4));
  endfunction

  function automatic logic [11:0] exp_col(input int a);
    logic [9:0] dx, dy;
    dx = exp_dx(a);
    dy = exp_dy(a);
    return {4'h0, dx[3:0], dy[3:0]};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".init"},      64'(bus.init),      64'd0);
    check({tag, ".dir"},       64'(bus.dir),       64'd0);
    check({tag, ".ray_valid"}, 64'(bus.ray_valid), 64'd0);
    check({tag, ".fb_we"},     64'(bus.fb_we),     64'd0);
    check({tag, ".fb_addr"},   64'(bus.fb_addr),   64'd0);
    check({tag, ".fb_data"},   64'(bus.fb_data),   64'd0);
    check({tag, ".busy"},      64'(bus.busy),      64'd0);
    check({tag, ".done"},      64'(bus.done),      64'd0);
  endtask

  // Starts a frame (cycle 0 = start high) and checks every cycle against rc[] and done_c.
  task automatic run_frame(input int done_c, input int p_lo, input int p_hi,
                           input logic [27:0] cam, input int ign1, input int ign2);
    int ri, wi;
    @(posedge clk); #1;
    bus.cam_pos = cam;
    bus.start   = 1'b1;
    for (int c = 1; c <= done_c + 5; c++) begin
      @(posedge clk); #1;
      bus.start = (c == ign1) || (c == ign2);
      if (c == ign1) bus.cam_pos = ~cam;
      bus.pause = (c >= p_lo) && (c <= p_hi);
      @(negedge clk);
      ri = -1;
      wi = -1;
      for (int k = 0; k < 8; k++) begin
        if (rc[k] == c) ri = k;
        if (rc[k] + 4 == c) wi = k;
      end
      check($sformatf("ray_valid@%0d", c), 64'(bus.ray_valid), 64'(ri >= 0));
      if (ri >= 0) begin
        check($sformatf("dir@%0d", c), 64'(bus.dir), 64'({exp_dx(ri), exp_dy(ri), 11'd512}));
        check($sformatf("init@%0d", c), 64'(bus.init), 64'(cam));
      end
      check($sformatf("fb_we@%0d", c), 64'(bus.fb_we), 64'(wi >= 0));
      if (wi >= 0) begin
        check($sformatf("fb_addr@%0d", c), 64'(bus.fb_addr), 64'(wi));
        check($sformatf("fb_data@%0d", c), 64'(bus.fb_data), 64'(exp_col(wi)));
      end
      check($sformatf("busy@%0d", c), 64'(bus.busy), 64'((c >= 1) && (c < done_c)));
      check($sformatf("done@%0d", c), 64'(bus.done), 64'(c == done_c));
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.cam_pos = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Plain frame
    rc = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame(13, 0, -1, 28'h1234567, -1, -1);

    // Pause in cycles 3-4
    rc = '{1, 2, 5, 6, 7, 8, 9, 10};
    run_frame(15, 3, 4, 28'h0abcdef, -1, -1);

    // Start ignored mid-frame (with new cam_pos) and in DONE
    rc = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame(13, 0, -1, 28'h7654321, 3, 13);

    // Reset at cycle 4 of a frame
    @(posedge clk); #1;
    bus.cam_pos = 28'h5a5a5a5;
    bus.start   = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      rst = (c == 4);
      @(negedge clk);
      if (c <= 4) begin
        check($sformatf("rst.ray_valid@%0d", c), 64'(bus.ray_valid), 64'd1);
        check($sformatf("rst.dir@%0d", c), 64'(bus.dir), 64'({exp_dx(c-1), exp_dy(c-1), 11'd512}));
      end else if (c == 5) begin
        check_zero("rst.c5");
      end else begin
        check($sformatf("rst.fb_we@%0d", c), 64'(bus.fb_we), 64'd0);
        check($sformatf("rst.ray_valid@%0d", c), 64'(bus.ray_valid), 64'd0);
      end
    end
    rst = 1'b0;
    run_frame(13, 0, -1, 28'h1234567, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
